meter_pulse_accumulator: RTL and testbench



---
 rtl/ebm_pkg.sv | 24 ++
 rtl/pulse_debouncer.sv | 55 +++++
 rtl/meter_pulse_accumulator.sv | 114 +++++++++++
 tb/tb_meter_pulse_accumulator.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebm_pkg.sv
// ============================================================================
// Module      : ebm_pkg
// Description : Shared widths, unit type and snapshot FSM encoding for the
//               energy billing machine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ebm_pkg;

   localparam int UNITS_W              = 13;
   localparam int DEF_PULSES_PER_UNIT  = 16;
   localparam int DEF_DEBOUNCE_CYCLES  = 4;

   typedef logic [UNITS_W-1:0] units_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_VALID = 1'b1
   } snapState_t;

endpackage

`default_nettype wire

// File: rtl/pulse_debouncer.sv
// ============================================================================
// Module      : pulse_debouncer
// Description : Two-flop synchroniser, stability filter and registered
//               rising-edge strobe for the raw meter impulse line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_debouncer #(
   parameter int DEBOUNCE_CYCLES = ebm_pkg::DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_in,
   output logic strobe_out
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_cntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_filtered;
   logic [CNT_W-1:0] r_cnt;
   logic             r_strobe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_filtered <= 1'b0;
         r_cnt      <= '0;
         r_strobe   <= 1'b0;
      end else begin
         r_sync1  <= raw_in;
         r_sync2  <= r_sync1;
         r_strobe <= 1'b0;
         if (r_sync2 == r_filtered) begin
            r_cnt <= '0;
         end else if (r_cnt == c_cntLast) begin
            // Strobe is raised on the same edge the filtered level rises
            r_filtered <= r_sync2;
            r_cnt      <= '0;
            r_strobe   <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign strobe_out = r_strobe;

endmodule

`default_nettype wire

// File: rtl/meter_pulse_accumulator.sv
// ============================================================================
// Module      : meter_pulse_accumulator
// Description : Divides debounced meter impulses into units, keeps the unit
//               register and hands snapshots to billing via req/valid/ack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module meter_pulse_accumulator #(
   parameter int PULSES_PER_UNIT = ebm_pkg::DEF_PULSES_PER_UNIT,
   parameter int DEBOUNCE_CYCLES = ebm_pkg::DEF_DEBOUNCE_CYCLES,
   parameter int UNITS_W         = ebm_pkg::UNITS_W
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               pulse_in,
   input  logic                               load_en,
   input  logic [UNITS_W-1:0]                 load_value,
   input  logic                               read_req,
   input  logic                               read_ack,
   output logic                               read_valid,
   output logic [UNITS_W-1:0]                 units_snap,
   output logic [UNITS_W-1:0]                 units_live,
   output logic [$clog2(PULSES_PER_UNIT)-1:0] pulse_cnt,
   output logic                               overflow
);

   import ebm_pkg::*;

   localparam int PC_W = $clog2(PULSES_PER_UNIT);
   localparam logic [PC_W-1:0]    c_cntLast  = PC_W'(PULSES_PER_UNIT - 1);
   localparam logic [UNITS_W-1:0] c_unitsMax = '1;

   logic               w_strobe;
   logic [PC_W-1:0]    r_pulseCnt;
   logic [UNITS_W-1:0] r_unitsLive;
   logic [UNITS_W-1:0] r_unitsSnap;
   logic               r_overflow;
   snapState_t         r_state;
   snapState_t         w_nextState;
   logic               w_capture;

   pulse_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (pulse_in),
      .strobe_out (w_strobe)
   );

   // A load wins over a coincident strobe; that impulse is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pulseCnt  <= '0;
         r_unitsLive <= '0;
         r_overflow  <= 1'b0;
      end else if (load_en) begin
         r_pulseCnt  <= '0;
         r_unitsLive <= load_value;
         r_overflow  <= 1'b0;
      end else if (w_strobe) begin
         if (r_pulseCnt < c_cntLast) begin
            r_pulseCnt <= r_pulseCnt + 1'b1;
         end else begin
            r_pulseCnt  <= '0;
            r_unitsLive <= r_unitsLive + 1'b1;
            if (r_unitsLive == c_unitsMax) begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_unitsSnap <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_capture) begin
            r_unitsSnap <= r_unitsLive;
         end
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (read_req) begin
               w_capture   = 1'b1;
               w_nextState = ST_VALID;
            end
         end
         ST_VALID: begin
            if (read_ack) begin
               w_nextState = ST_IDLE;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   assign read_valid = (r_state == ST_VALID);
   assign units_snap = r_unitsSnap;
   assign units_live = r_unitsLive;
   assign pulse_cnt  = r_pulseCnt;
   assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_meter_pulse_accumulator.sv
// ============================================================================
// Module      : tb_meter_pulse_accumulator
// Description : Directed self-checking bench with a window-based reference
//               model compared against the accumulator every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_meter_pulse_accumulator;

   localparam int PPU = 16;
   localparam int DB  = 4;
   localparam int UW  = 13;

   logic          clk = 1'b0;
   logic          rst;
   logic          pulse_in;
   logic          load_en;
   logic [UW-1:0] load_value;
   logic          read_req;
   logic          read_ack;
   logic          read_valid;
   logic [UW-1:0] units_snap;
   logic [UW-1:0] units_live;
   logic [3:0]    pulse_cnt;
   logic          overflow;

   int checks   = 0;
   int failures = 0;

   meter_pulse_accumulator #(
      .PULSES_PER_UNIT (PPU),
      .DEBOUNCE_CYCLES (DB),
      .UNITS_W         (UW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pulse_in   (pulse_in),
      .load_en    (load_en),
      .load_value (load_value),
      .read_req   (read_req),
      .read_ack   (read_ack),
      .read_valid (read_valid),
      .units_snap (units_snap),
      .units_live (units_live),
      .pulse_cnt  (pulse_cnt),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the filtered level flips once the last DB synchronised
   // samples all disagree with it; a rising flip is counted one edge later.
   int mLive, mCnt, mSnap;
   bit mOvf, mValid, mLevel, mStrobe, stable;
   bit hist [0:DB+1];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mLive = 0; mCnt = 0; mSnap = 0;
         mOvf = 0; mValid = 0; mLevel = 0; mStrobe = 0;
         for (int i = 0; i <= DB + 1; i++) hist[i] = 1'b0;
      end else begin
         if (!mValid) begin
            if (read_req) begin
               mSnap  = mLive;
               mValid = 1'b1;
            end
         end else if (read_ack) begin
            mValid = 1'b0;
         end
         if (load_en) begin
            mLive = int'(load_value);
            mCnt  = 0;
            mOvf  = 1'b0;
         end else if (mStrobe) begin
            mCnt++;
            if (mCnt == PPU) begin
               mCnt  = 0;
               mLive = (mLive + 1) % (1 << UW);
               if (mLive == 0) mOvf = 1'b1;
            end
         end
         mStrobe = 1'b0;
         for (int i = DB + 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = pulse_in;
         stable = 1'b1;
         for (int i = 2; i <= DB + 1; i++) if (hist[i] == mLevel) stable = 1'b0;
         if (stable) begin
            mLevel  = ~mLevel;
            mStrobe = mLevel;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("model_live",  32'(units_live), 32'(mLive));
         chk("model_cnt",   32'(pulse_cnt),  32'(mCnt));
         chk("model_ovf",   32'(overflow),   32'(mOvf));
         chk("model_valid", 32'(read_valid), 32'(mValid));
         if (mValid) chk("model_snap", 32'(units_snap), 32'(mSnap));
      end
   end

   task automatic pulses(input int n, input int hi, input int lo);
      for (int k = 0; k < n; k++) begin
         pulse_in = 1'b1;
         repeat (hi) @(negedge clk);
         pulse_in = 1'b0;
         repeat (lo) @(negedge clk);
      end
   endtask

   task automatic drain();
      repeat (DB + 6) @(negedge clk);
   endtask

   task automatic doLoad(input int v);
      load_value = UW'(v);
      load_en    = 1'b1;
      @(negedge clk);
      load_en    = 1'b0;
   endtask

   task automatic doReq();
      read_req = 1'b1;
      @(negedge clk);
      read_req = 1'b0;
   endtask

   task automatic doAck();
      read_ack = 1'b1;
      @(negedge clk);
      read_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; pulse_in = 1'b0; load_en = 1'b0; load_value = '0;
      read_req = 1'b0; read_ack = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Asynchronous reset in the middle of a cycle, with state populated
      doLoad(7);
      pulses(3, 6, 6);
      drain();
      doReq();
      chk("pre_rst_valid", 32'(read_valid), 32'd1);
      chk("pre_rst_snap",  32'(units_snap), 32'd7);
      pulse_in = 1'b1;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst_live",  32'(units_live), 32'd0);
      chk("rst_cnt",   32'(pulse_cnt),  32'd0);
      chk("rst_ovf",   32'(overflow),   32'd0);
      chk("rst_valid", 32'(read_valid), 32'd0);
      chk("rst_snap",  32'(units_snap), 32'd0);
      @(negedge clk);
      pulse_in = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (DB + 5) @(negedge clk);
      chk("post_rst_cnt", 32'(pulse_cnt), 32'd0);

      // Division
      doLoad(100);
      pulses(32, 6, 6);
      drain();
      chk("div_live", 32'(units_live), 32'd102);
      chk("div_cnt",  32'(pulse_cnt),  32'd0);
      pulses(5, 6, 6);
      drain();
      chk("div5_live", 32'(units_live), 32'd102);
      chk("div5_cnt",  32'(pulse_cnt),  32'd5);

      // Short glitches are filtered; a clean pulse lands DB+3 clocks after its rise
      pulses(10, 3, 6);
      drain();
      chk("glitch_cnt", 32'(pulse_cnt), 32'd5);
      pulse_in = 1'b1;
      repeat (DB + 2) @(negedge clk);
      chk("lat_before", 32'(pulse_cnt), 32'd5);
      @(negedge clk);
      chk("lat_at", 32'(pulse_cnt), 32'd6);
      pulse_in = 1'b0;
      drain();

      // Wrap and overflow
      doLoad(8191);
      pulses(15, 6, 6);
      drain();
      chk("wrap_pre_cnt",  32'(pulse_cnt),  32'd15);
      chk("wrap_pre_live", 32'(units_live), 32'd8191);
      pulses(1, 6, 6);
      drain();
      chk("wrap_live", 32'(units_live), 32'd0);
      chk("wrap_ovf",  32'(overflow),   32'd1);
      doLoad(50);
      chk("reload_ovf",  32'(overflow),   32'd0);
      chk("reload_live", 32'(units_live), 32'd50);

      // Handshake
      doLoad(300);
      doReq();
      chk("hs_valid", 32'(read_valid), 32'd1);
      chk("hs_snap",  32'(units_snap), 32'd300);
      pulses(16, 6, 6);
      drain();
      chk("hs_live",   32'(units_live), 32'd301);
      chk("hs_frozen", 32'(units_snap), 32'd300);
      doReq();
      @(negedge clk);
      chk("hs_req_ign", 32'(units_snap), 32'd300);
      doAck();
      chk("hs_ack", 32'(read_valid), 32'd0);
      doAck();
      read_req = 1'b1; read_ack = 1'b1;
      @(negedge clk);
      read_req = 1'b0; read_ack = 1'b0;
      chk("hs_both_valid", 32'(read_valid), 32'd1);
      chk("hs_both_snap",  32'(units_snap), 32'd301);
      doAck();

      // Load collides with a strobe
      doLoad(40);
      pulse_in = 1'b1;
      repeat (DB + 2) @(negedge clk);
      load_value = UW'(77);
      load_en    = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
      chk("coll_live", 32'(units_live), 32'd77);
      chk("coll_cnt",  32'(pulse_cnt),  32'd0);
      pulse_in = 1'b0;
      drain();
      chk("coll_cnt_after", 32'(pulse_cnt), 32'd0);

      // Snapshot request on the edge the unit count steps 499 -> 500
      doLoad(499);
      pulses(15, 6, 6);
      drain();
      pulse_in = 1'b1;
      repeat (DB + 2) @(negedge clk);
      read_req = 1'b1;
      @(negedge clk);
      read_req = 1'b0;
      chk("edge_live",  32'(units_live), 32'd500);
      chk("edge_snap",  32'(units_snap), 32'd499);
      chk("edge_valid", 32'(read_valid), 32'd1);
      pulse_in = 1'b0;
      drain();
      doAck();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
